stream_kat_checker: RTL and testbench
=====================================

Name: stream_kat_checker

Overview:
- Synthesizable self-checking sink for word streams produced by the KEM core (`main`).
- Consumes a DUT output stream and an expected-vector stream in lockstep, over a commanded number of words.
- Counts mismatches, captures the first failing word, optionally byte-swaps the DUT word, and flags a stalled stream via a timeout.
- Generalises the bench's receive/compare flow to any word width and vector length.
- Built for FPGA self-test of all parameter sets (640/976/1344).

Parameters:
- WORD_W, 64, data word width in bits; must be a multiple of 8.
- LEN_W, 20, width of the word-count field; max run is 2^LEN_W-1 words.
- ERR_W, 16, width of the mismatch counter; the counter saturates.
- TIMEOUT, 1000000, idle cycles in RUN before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  LEN_W+2  {swap, drain, len[LEN_W-1:0]}.
- cmd_isReady  in  1  cmd valid.
- cmd_canReceive  out  1  checker idle, accepts cmd.
- in  in  WORD_W  DUT output word.
- in_isReady  in  1  DUT word valid.
- in_canReceive  out  1  checker takes DUT word.
- exp  in  WORD_W  expected word.
- exp_isReady  in  1  expected word valid.
- exp_canReceive  out  1  checker takes expected word.
- res_isReady  out  1  result valid (DONE state).
- res_canReceive  in  1  result consumed.
- res_pass  out  1  run completed, zero mismatches, no timeout.
- res_timeout  out  1  run aborted by timeout.
- res_errCount  out  ERR_W  mismatch count, saturating.
- res_firstIdx  out  LEN_W  word index of first mismatch.
- res_firstGot  out  WORD_W  DUT word (post-swap) at first mismatch.
- res_firstExp  out  WORD_W  expected word at first mismatch.

Behaviour:
- Reset: state IDLE; all res_* = 0; cmd_canReceive = 1; in_canReceive = exp_canReceive = 0. Reset mid-run aborts with no result.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - cmd_canReceive = 1; cmd accepted on a cycle with cmd_isReady=1.
  - On accept, latch swap, drain and len; clear the word index, error counter, first-error registers and idle counter.
  - Next state is RUN, or DONE directly if len = 0 (pass=1).
- RUN, compare mode (drain=0):
  - in_canReceive = exp_isReady; exp_canReceive = in_isReady.
  - A transfer occurs when in_isReady & exp_isReady; both words are consumed in the same cycle.
  - The sources' isReady must not depend combinationally on canReceive.
- RUN, drain mode (drain=1):
  - in_canReceive = 1; exp_canReceive = 0; words are counted but never compared.
  - A drain run always passes unless it times out.
- Swap: when swap=1, the DUT word is byte-reversed before compare and capture (byte k <-> byte WORD_W/8-1-k).
- Mismatch on a transfer: got != exp.
  - res_errCount increments, holding at 2^ERR_W-1.
  - If this is the first mismatch, capture the index, got and exp words.
- Word index increments per transfer. The transfer with index len-1 moves to DONE the next cycle; no further words are accepted.
- Timeout: the idle counter clears on every transfer and increments otherwise. When it reaches TIMEOUT: DONE, res_timeout=1, res_pass=0; the partial errCount is kept.
- DONE:
  - res_isReady = 1; res_pass = (errCount==0) & ~timeout.
  - All res_* are stable until a cycle with res_canReceive=1, then state returns to IDLE.
  - res_* keep their values in IDLE until the next cmd accept.
- cmd_canReceive = 0 outside IDLE. A cmd presented during RUN or DONE is ignored, not queued.
- In every state other than RUN: in_canReceive = exp_canReceive = 0.

Test Plan:
1. Compare, len=4, WORD_W=64: both streams send 0x0102030405060708+i, i=0..3 -> DONE after the 4th transfer; pass=1, errCount=0.
2. Compare with swap, len=2: DUT sends 0x0807060504030201 and expected is 0x0102030405060708, then one corrupted word -> errCount=1, firstIdx=1, pass=0.
3. Mismatch capture, len=8, words 2 and 5 wrong, exp stalls 3 cycles between words -> errCount=2, firstIdx=2, firstGot/firstExp = word-2 values; no extra words consumed.
4. Drain, len=2688 (one 172032-bit matrix), exp_isReady=0 throughout -> exp_canReceive never asserted; pass=1 after 2688 transfers.
5. TIMEOUT=16, len=10, DUT stops after 3 words -> DONE exactly 16 idle cycles after the 3rd transfer; timeout=1, pass=0, errCount=0.
6. len=0 -> res_isReady the cycle after accept with pass=1. Reset asserted during RUN -> IDLE next cycle, res_* cleared. Cmd sent while in DONE -> ignored.

Source files
------------

// File: rtl/stream_kat_checker_if.sv
// Handshake bundle between the KAT checker and its command/data/result endpoints.
interface stream_kat_checker_if #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned LEN_W  = 20,
    parameter int unsigned ERR_W  = 16
);
    logic [LEN_W+1:0]  cmd;
    logic              cmd_isReady;
    logic              cmd_canReceive;
    logic [WORD_W-1:0] in;
    logic              in_isReady;
    logic              in_canReceive;
    logic [WORD_W-1:0] exp;
    logic              exp_isReady;
    logic              exp_canReceive;
    logic              res_isReady;
    logic              res_canReceive;
    logic              res_pass;
    logic              res_timeout;
    logic [ERR_W-1:0]  res_errCount;
    logic [LEN_W-1:0]  res_firstIdx;
    logic [WORD_W-1:0] res_firstGot;
    logic [WORD_W-1:0] res_firstExp;

    // Checker side
    modport slave (
        input  cmd, cmd_isReady, in, in_isReady, exp, exp_isReady, res_canReceive,
        output cmd_canReceive, in_canReceive, exp_canReceive, res_isReady, res_pass,
               res_timeout, res_errCount, res_firstIdx, res_firstGot, res_firstExp
    );

    // Environment side
    modport master (
        output cmd, cmd_isReady, in, in_isReady, exp, exp_isReady, res_canReceive,
        input  cmd_canReceive, in_canReceive, exp_canReceive, res_isReady, res_pass,
               res_timeout, res_errCount, res_firstIdx, res_firstGot, res_firstExp
    );
endinterface

// File: rtl/stream_kat_checker.sv
// Lockstep compare sink: checks a DUT word stream against an expected stream,
// counts mismatches, captures the first failure and aborts a stalled run.
module stream_kat_checker #(
    parameter int unsigned WORD_W  = 64,
    parameter int unsigned LEN_W   = 20,
    parameter int unsigned ERR_W   = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_kat_checker_if.slave  bus
);
    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              swap_q, drain_q;
    logic [LEN_W-1:0]  len_q, idx_q;
    logic [ERR_W-1:0]  err_q;
    logic [LEN_W-1:0]  first_idx_q;
    logic [WORD_W-1:0] first_got_q, first_exp_q;
    logic [IDLE_W-1:0] idle_q;
    logic              timeout_q;
    logic              valid_q;  // a completed result is being presented

    logic              cmd_acc;
    logic              xfer;
    logic              last_xfer;
    logic              timeout_hit;
    logic              mismatch;
    logic [WORD_W-1:0] got_word;
    logic [LEN_W-1:0]  cmd_len;

    assign cmd_len = bus.cmd[LEN_W-1:0];

    // Optional byte reversal of the DUT word ahead of compare and capture
    always_comb begin
        got_word = bus.in;
        if (swap_q) begin
            for (int k = 0; k < NBYTES; k++) begin
                got_word[8*k +: 8] = bus.in[8*(NBYTES-1-k) +: 8];
            end
        end
    end

    // Transfer / terminal-condition decode
    always_comb begin
        cmd_acc     = (state_q == StIdle) && bus.cmd_isReady;
        xfer        = (state_q == StRun) && bus.in_isReady && (drain_q || bus.exp_isReady);
        last_xfer   = xfer && (idx_q == len_q - LEN_W'(1));
        mismatch    = xfer && !drain_q && (got_word != bus.exp);
        timeout_hit = (TIMEOUT != 0) && (state_q == StRun) && !xfer &&
                      (idle_q == IDLE_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_isReady) begin
                    state_d = (cmd_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_xfer || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_canReceive) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and result outputs
    always_comb begin
        bus.cmd_canReceive = (state_q == StIdle);
        bus.in_canReceive  = (state_q == StRun) && (drain_q || bus.exp_isReady);
        bus.exp_canReceive = (state_q == StRun) && !drain_q && bus.in_isReady;
        bus.res_isReady    = (state_q == StDone);
        bus.res_pass       = valid_q && (err_q == '0) && !timeout_q;
        bus.res_timeout    = timeout_q;
        bus.res_errCount   = err_q;
        bus.res_firstIdx   = first_idx_q;
        bus.res_firstGot   = first_got_q;
        bus.res_firstExp   = first_exp_q;
    end

    // Run bookkeeping: command latch, word index, error capture, idle timer
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_q      <= 1'b0;
            drain_q     <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
            idle_q      <= '0;
            timeout_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else if (cmd_acc) begin
            swap_q      <= bus.cmd[LEN_W+1];
            drain_q     <= bus.cmd[LEN_W];
            len_q       <= cmd_len;
            idx_q       <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
            idle_q      <= '0;
            timeout_q   <= 1'b0;
            valid_q     <= (cmd_len == '0);
        end else if (state_q == StRun) begin
            if (xfer) begin
                idx_q  <= idx_q + LEN_W'(1);
                idle_q <= '0;
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    // Counter never wraps, so zero means nothing captured yet
                    if (err_q == '0) begin
                        first_idx_q <= idx_q;
                        first_got_q <= got_word;
                        first_exp_q <= bus.exp;
                    end
                end
            end else begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (state_d == StDone) begin
                valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_kat_checker.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized runs scored against a queue-based reference model.
module tb_stream_kat_checker;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned LEN_W  = 20;
    localparam int unsigned ERR_W  = 16;
    localparam logic [63:0] BASE   = 64'h0102030405060708;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_kat_checker_if #(.WORD_W(WORD_W), .LEN_W(LEN_W), .ERR_W(ERR_W)) bus ();

    stream_kat_checker #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W),
        .ERR_W  (ERR_W),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int len;
        bit swap;
        bit drain;
        int bad0;
        int bad1;
        int exp_gap;
        int extra;
        bit exp_pass;
        int exp_err;
        int exp_first;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] dw[$];
    logic [63:0] ew[$];

    int r_consumed, r_done_cyc, r_last_xfer, r_lock_err;
    bit r_exp_seen, r_done, r_in_can_done;

    int          m_err, m_first;
    bit          m_pass;
    logic [63:0] m_fgot, m_fexp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] rev(input logic [63:0] w);
        logic [63:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    // Reference: walk the first len words, compare post-swap, remember the first miss
    task automatic model(input int len, input bit swap, input bit drain);
        logic [63:0] g;
        m_err = 0; m_first = 0; m_fgot = '0; m_fexp = '0;
        if (!drain) begin
            for (int i = 0; i < len; i++) begin
                if (swap) g = rev(dw[i]);
                else g = dw[i];
                if (g != ew[i]) begin
                    if (m_err == 0) begin
                        m_first = i; m_fgot = g; m_fexp = ew[i];
                    end
                    if (m_err < (1 << ERR_W) - 1) m_err++;
                end
            end
        end
        m_pass = (m_err == 0);
    endtask

    // Issue a command, then feed up to n_send words per side until the result shows
    task automatic run_stream(input int len, input bit swap, input bit drain, input int n_send,
                              input int exp_gap, input bit rnd);
        int ip, ep, gap, idle;
        bit xi, xe;
        ip = 0; ep = 0; gap = 0; idle = 0;
        r_lock_err = 0; r_exp_seen = 0; r_done = 0; r_last_xfer = -1; r_done_cyc = -1;
        r_in_can_done = 0;
        @(negedge clk);
        bus.cmd = {swap, drain, LEN_W'(len)};
        bus.cmd_isReady = 1'b1;
        @(negedge clk);
        bus.cmd_isReady = 1'b0;
        for (int cyc = 0; cyc < 4 * len + 200; cyc++) begin
            bus.in_isReady = (ip < n_send) && (!rnd || $urandom_range(0, 3) != 0 || idle >= 5);
            if (ip < n_send) bus.in = dw[ip];
            bus.exp_isReady = !drain && (ep < n_send) && (gap == 0) &&
                              (!rnd || $urandom_range(0, 3) != 0 || idle >= 5);
            if (ep < n_send) bus.exp = ew[ep];
            #1;
            if (bus.res_isReady) begin
                r_done = 1; r_done_cyc = cyc; r_in_can_done = bus.in_canReceive;
                break;
            end
            if (bus.exp_canReceive) r_exp_seen = 1;
            xi = bus.in_isReady && bus.in_canReceive;
            xe = bus.exp_isReady && bus.exp_canReceive;
            if (!drain && (xi != xe)) r_lock_err++;
            if (xi) begin
                ip++; r_last_xfer = cyc; idle = 0;
            end else begin
                idle++;
            end
            if (xe) begin
                ep++; gap = exp_gap;
            end else if (gap > 0) begin
                gap--;
            end
            @(negedge clk);
        end
        r_consumed = ip;
        bus.in_isReady = 1'b0;
        bus.exp_isReady = 1'b0;
    endtask

    task automatic finish_result();
        @(negedge clk);
        bus.res_canReceive = 1'b1;
        @(negedge clk);
        bus.res_canReceive = 1'b0;
        #1;
        check("idle_after_ack", bus.cmd_canReceive, 1);
        check("res_drop_after_ack", bus.res_isReady, 0);
    endtask

    task automatic check_run(input string tag, input int len, input bit drain, input bit timed_out);
        check({tag, "_done"}, r_done, 1);
        check({tag, "_pass"}, bus.res_pass, m_pass);
        check({tag, "_err"}, bus.res_errCount, m_err);
        check({tag, "_timeout"}, bus.res_timeout, timed_out);
        check({tag, "_first_idx"}, bus.res_firstIdx, m_first);
        check({tag, "_first_got"}, bus.res_firstGot, m_fgot);
        check({tag, "_first_exp"}, bus.res_firstExp, m_fexp);
        check({tag, "_in_can_in_done"}, r_in_can_done, 0);
        if (!timed_out) begin
            check({tag, "_consumed"}, r_consumed, len);
            if (len > 0) check({tag, "_done_latency"}, r_done_cyc - r_last_xfer, 1);
        end
        if (drain) check({tag, "_exp_can_seen"}, r_exp_seen, 0);
        else check({tag, "_lockstep"}, r_lock_err, 0);
    endtask

    vec_t vecs[4];

    initial begin
        logic [63:0] e, d;
        int len, extra;
        bit swap, drain;

        vecs[0] = '{len: 4,    swap: 0, drain: 0, bad0: -1, bad1: -1, exp_gap: 0, extra: 0,
                    exp_pass: 1, exp_err: 0, exp_first: 0};
        vecs[1] = '{len: 2,    swap: 1, drain: 0, bad0: 1,  bad1: -1, exp_gap: 0, extra: 0,
                    exp_pass: 0, exp_err: 1, exp_first: 1};
        vecs[2] = '{len: 8,    swap: 0, drain: 0, bad0: 2,  bad1: 5,  exp_gap: 3, extra: 2,
                    exp_pass: 0, exp_err: 2, exp_first: 2};
        vecs[3] = '{len: 2688, swap: 0, drain: 1, bad0: -1, bad1: -1, exp_gap: 0, extra: 0,
                    exp_pass: 1, exp_err: 0, exp_first: 0};

        bus.cmd = '0; bus.cmd_isReady = 0; bus.in = '0; bus.in_isReady = 1;
        bus.exp = '0; bus.exp_isReady = 1; bus.res_canReceive = 0;

        // Reset state, with both sources offering words
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_can", bus.cmd_canReceive, 1);
        check("rst_in_can", bus.in_canReceive, 0);
        check("rst_exp_can", bus.exp_canReceive, 0);
        check("rst_res_valid", bus.res_isReady, 0);
        check("rst_res_pass", bus.res_pass, 0);
        check("rst_res_err", bus.res_errCount, 0);
        rst = 0;
        bus.in_isReady = 0; bus.exp_isReady = 0;

        // Directed table
        foreach (vecs[v]) begin
            dw.delete(); ew.delete();
            for (int i = 0; i < vecs[v].len + vecs[v].extra; i++) begin
                e = BASE + 64'(i);
                if (vecs[v].swap) d = rev(e);
                else d = e;
                if (i == vecs[v].bad0 || i == vecs[v].bad1) d = d ^ 64'h1;
                ew.push_back(e); dw.push_back(d);
            end
            run_stream(vecs[v].len, vecs[v].swap, vecs[v].drain, vecs[v].len + vecs[v].extra,
                       vecs[v].exp_gap, 0);
            m_pass = vecs[v].exp_pass; m_err = vecs[v].exp_err; m_first = vecs[v].exp_first;
            m_fgot = '0; m_fexp = '0;
            if (vecs[v].exp_err > 0) begin
                m_fexp = BASE + 64'(vecs[v].exp_first);
                m_fgot = m_fexp ^ (vecs[v].swap ? 64'h0100_0000_0000_0000 : 64'h1);
            end
            check_run($sformatf("vec%0d", v), vecs[v].len, vecs[v].drain, 0);
            finish_result();
            if (vecs[v].exp_err > 0) begin
                check($sformatf("vec%0d_err_held_idle", v), bus.res_errCount, vecs[v].exp_err);
            end
        end

        // Timeout: 10 words commanded, DUT delivers only 3
        dw.delete(); ew.delete();
        for (int i = 0; i < 10; i++) begin
            dw.push_back(BASE + 64'(i)); ew.push_back(BASE + 64'(i));
        end
        run_stream(10, 0, 0, 3, 0, 0);
        m_pass = 0; m_err = 0; m_first = 0; m_fgot = '0; m_fexp = '0;
        check_run("tmo", 10, 0, 1);
        check("tmo_consumed", r_consumed, 3);
        check("tmo_latency", r_done_cyc - r_last_xfer, 17);

        // Command offered while a result is pending must be dropped
        @(negedge clk);
        bus.cmd = {1'b0, 1'b1, LEN_W'(5)}; bus.cmd_isReady = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("done_cmd_can", bus.cmd_canReceive, 0);
        check("done_hold_valid", bus.res_isReady, 1);
        check("done_hold_tmo", bus.res_timeout, 1);
        bus.cmd_isReady = 0;
        finish_result();
        repeat (2) @(negedge clk);
        #1;
        check("no_queued_cmd", bus.cmd_canReceive, 1);
        check("idle_keeps_tmo", bus.res_timeout, 1);

        // Zero-length command finishes immediately with a pass
        dw.delete(); ew.delete();
        run_stream(0, 0, 0, 0, 0, 0);
        model(0, 0, 0);
        check("len0_latency", r_done_cyc, 0);
        check_run("len0", 0, 0, 0);
        finish_result();

        // Reset in the middle of a run
        @(negedge clk);
        bus.cmd = {1'b0, 1'b0, LEN_W'(5)}; bus.cmd_isReady = 1;
        @(negedge clk);
        bus.cmd_isReady = 0;
        bus.in = 64'h1; bus.exp = 64'h2; bus.in_isReady = 1; bus.exp_isReady = 1;
        repeat (2) @(negedge clk);
        #1;
        check("midrun_err", bus.res_errCount, 2);
        check("midrun_cmd_can", bus.cmd_canReceive, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("midrst_cmd_can", bus.cmd_canReceive, 1);
        check("midrst_in_can", bus.in_canReceive, 0);
        check("midrst_valid", bus.res_isReady, 0);
        check("midrst_err", bus.res_errCount, 0);
        check("midrst_first_got", bus.res_firstGot, 0);
        bus.in_isReady = 0; bus.exp_isReady = 0;

        // Randomized runs against the reference model
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 24);
            swap = 1'($urandom_range(0, 1));
            drain = ($urandom_range(0, 9) == 0);
            extra = $urandom_range(0, 2);
            dw.delete(); ew.delete();
            for (int i = 0; i < len + extra; i++) begin
                e = {$urandom, $urandom};
                if (swap) d = rev(e);
                else d = e;
                if ($urandom_range(0, 3) == 0) d = d ^ (64'h1 << $urandom_range(0, 63));
                ew.push_back(e); dw.push_back(d);
            end
            run_stream(len, swap, drain, len + extra, 0, 1);
            model(len, swap, drain);
            check_run($sformatf("rnd%0d", t), len, drain, 0);
            finish_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
